// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   state_t     : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   OWNER_CORE  : owner encoding for the processor load/store port
//   OWNER_HOST  : owner encoding for the host/debug loader port
//   RD_LAT_MAX  : largest supported memory read latency
//   CNT_W       : width of the read-latency down-counter
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

    // A doubleword access is legal only when the three low address bits are zero.
    function automatic logic is_dword_aligned(input logic [2:0] i_lsbs);
        return (i_lsbs == 3'b000);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// ---------------------------------------------------------------------------
// dmem_arb_pick
// Combinational winner selection between the core and host request ports.
// Configuration macro: DMEM_ARB_CORE_PRIO_EN
//   defined   : fixed priority, the core wins every contention
//   undefined : round-robin, contention goes to the port not granted last
// Ports:
//   i_c_valid    : core request valid
//   i_h_valid    : host request valid
//   i_last_owner : owner of the previous grant (round-robin build only)
//   o_any        : at least one request is pending
//   o_winner     : selected owner (OWNER_CORE / OWNER_HOST)
// ---------------------------------------------------------------------------
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic i_c_valid,
    input  logic i_h_valid,
`ifndef DMEM_ARB_CORE_PRIO_EN
    input  logic i_last_owner,
`endif
    output logic o_any,
    output logic o_winner
);

    // A lone requester always wins; only simultaneous requests consult the policy.
    always_comb begin
        o_any    = i_c_valid | i_h_valid;
        o_winner = OWNER_CORE;
        if (i_c_valid && i_h_valid) begin
`ifdef DMEM_ARB_CORE_PRIO_EN
            o_winner = OWNER_CORE;
`else
            o_winner = (i_last_owner == OWNER_CORE) ? OWNER_HOST : OWNER_CORE;
`endif
        end else if (i_h_valid) begin
            o_winner = OWNER_HOST;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the core load/store port and
// the host/debug loader port. One request is accepted at a time; the access
// is sequenced as a write or a fixed-latency read, and a one-cycle response
// is returned to the winner. Misaligned doubleword accesses are rejected
// without touching memory.
// Configuration macro: DMEM_ARB_CORE_PRIO_EN (fixed core priority when
// defined, round-robin otherwise).
// Ports:
//   clk, reset                   : clock (rising edge), async active-low reset
//   c_req_valid/ready, c_we,     : core request handshake and payload
//   c_addr, c_wdata
//   h_req_valid/ready, h_we,     : host request handshake and payload
//   h_addr, h_wdata
//   c_rsp_valid / h_rsp_valid    : one-cycle response pulse per requester
//   rsp_rdata, rsp_err           : shared response data / misalignment error
//   mem_addr, mem_wdata,         : memory request side
//   mem_we, mem_re
//   mem_rdata                    : memory read data, RD_LAT cycles after mem_re
//   busy                         : a transaction is in flight
//   owner                        : owner of the current/last transaction
// Parameters: RD_LAT (1..RD_LAT_MAX), ADDR_W, DATA_W
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req_valid,
    output logic              c_req_ready,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic              h_req_valid,
    output logic              h_req_ready,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              c_rsp_valid,
    output logic              h_rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    state_t              r_state;
    state_t              w_next;
    logic                r_we;
    logic                r_owner;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [CNT_W-1:0]    r_cnt;
`ifndef DMEM_ARB_CORE_PRIO_EN
    logic                r_last_owner;
`endif
    logic                w_any;
    logic                w_winner;
    logic                w_aligned;

    assign w_aligned = is_dword_aligned(r_addr[2:0]);

    dmem_arb_pick u_pick (
        .i_c_valid    (c_req_valid),
        .i_h_valid    (h_req_valid),
`ifndef DMEM_ARB_CORE_PRIO_EN
        .i_last_owner (r_last_owner),
`endif
        .o_any        (w_any),
        .o_winner     (w_winner)
    );

    // Memory side is driven straight from the latched request so address and
    // data stay stable from ISSUE through WAIT without extra muxing.
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign owner     = r_owner;
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobes. Readies exist only in IDLE, so a requester that
    // loses (or arrives while busy) simply keeps holding its request.
    always_comb begin
        w_next      = r_state;
        c_req_ready = 1'b0;
        h_req_ready = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        c_rsp_valid = 1'b0;
        h_rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    c_req_ready = (w_winner == OWNER_CORE);
                    h_req_ready = (w_winner == OWNER_HOST);
                    w_next      = ISSUE;
                end
            end
            ISSUE: begin
                if (!w_aligned) begin
                    w_next = RESP;
                end else if (r_we) begin
                    mem_we = 1'b1;
                    w_next = RESP;
                end else begin
                    mem_re = 1'b1;
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                c_rsp_valid = (r_owner == OWNER_CORE);
                h_rsp_valid = (r_owner == OWNER_HOST);
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch, error flag and read-latency counter. Response data and
    // error are cleared on accept so writes and errors respond with zero data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we         <= 1'b0;
            r_owner      <= OWNER_CORE;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_cnt        <= '0;
`ifndef DMEM_ARB_CORE_PRIO_EN
            r_last_owner <= OWNER_HOST;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_we    <= (w_winner == OWNER_HOST) ? h_we    : c_we;
                        r_addr  <= (w_winner == OWNER_HOST) ? h_addr  : c_addr;
                        r_wdata <= (w_winner == OWNER_HOST) ? h_wdata : c_wdata;
                        r_owner <= w_winner;
                        r_err   <= 1'b0;
                        r_rdata <= '0;
`ifndef DMEM_ARB_CORE_PRIO_EN
                        r_last_owner <= w_winner;
`endif
                    end
                end
                ISSUE: begin
                    if (!w_aligned) begin
                        r_err <= 1'b1;
                    end else if (!r_we) begin
                        r_cnt <= CNT_W'(RD_LAT);
                    end
                end
                WAIT: begin
                    // Counter value 1 marks the cycle the memory presents read data.
                    if (r_cnt == CNT_W'(1)) begin
                        r_rdata <= mem_rdata;
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
